// File: rtl/vga_scanout_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout_fsm
// Description : Read side of the NES frame buffer. Produces 640x480@60 VGA
//               timing, shows the 256x240 image doubled 2x in both axes and
//               centred horizontally, fetches pixels from vga_mem and expands
//               each byte to 12-bit RGB.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   pix_ce       in   1   pixel clock enable
//   vga_row      out  10  image row read address (0..239)
//   vga_col      out  10  image col read address (0..255)
//   vga_data     in   8   vga_mem read data, valid 1 clk after address
//   hsync        out  1   horizontal sync, active-low
//   vsync        out  1   vertical sync, active-low
//   de           out  1   display enable
//   red/green/blue out 4  pixel colour
//   vblank       out  1   high while the line counter is in vertical blanking
//   frame_start  out  1   single-clk pulse when counters wrap to (0,0)
// Configuration
//   NES_PALETTE_LUT_EN : when defined, the pixel byte indexes a 64-entry
//                        NES 2C02 palette (d[5:0]); otherwise RGB332 expand.
// ============================================================================
module vga_scanout_fsm #(
    parameter int          H_VIS      = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_VIS      = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          IMG_W      = 256,
    parameter int          IMG_H      = 240,
    parameter int          H_OFF      = 64,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    output logic [9:0] vga_row,
    output logic [9:0] vga_col,
    input  logic [7:0] vga_data,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       vblank,
    output logic       frame_start
);

    localparam logic [9:0] c_h_last   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_last   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_vis    = 10'(H_VIS);
    localparam logic [9:0] c_v_vis    = 10'(V_VIS);
    localparam logic [9:0] c_hs_start = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] c_img_x0   = 10'(H_OFF);
    localparam logic [9:0] c_img_x1   = 10'(H_OFF + 2 * IMG_W);
    localparam logic [9:0] c_img_y1   = 10'(2 * IMG_H);

    // Stage 0: raster counters
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_h_wrap;
    logic       w_v_wrap;

    // Stage 0 decodes
    logic       w_img;
    logic       w_vis;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic [9:0] w_img_col;
    logic [9:0] w_img_row;

    // Stage 1: address and control, aligned with the outstanding read
    logic [9:0] r_vga_row;
    logic [9:0] r_vga_col;
    logic       r_s1_img;
    logic       r_s1_vis;
    logic       r_s1_hs;
    logic       r_s1_vs;

    // Stage 2: outputs
    logic [11:0] r_rgb;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_frame_start;

    function automatic logic [11:0] colour(input logic [7:0] d);
`ifdef NES_PALETTE_LUT_EN
        logic [11:0] c;
        c = 12'h000;
        case (d[5:0])
            6'h00: c = 12'h777; 6'h01: c = 12'h00F; 6'h02: c = 12'h00B; 6'h03: c = 12'h42B;
            6'h04: c = 12'h908; 6'h05: c = 12'hA02; 6'h06: c = 12'hA10; 6'h07: c = 12'h810;
            6'h08: c = 12'h530; 6'h09: c = 12'h070; 6'h0A: c = 12'h060; 6'h0B: c = 12'h050;
            6'h0C: c = 12'h045; 6'h0D: c = 12'h000; 6'h0E: c = 12'h000; 6'h0F: c = 12'h000;
            6'h10: c = 12'hBBB; 6'h11: c = 12'h07F; 6'h12: c = 12'h05F; 6'h13: c = 12'h64F;
            6'h14: c = 12'hD0C; 6'h15: c = 12'hE05; 6'h16: c = 12'hF30; 6'h17: c = 12'hE51;
            6'h18: c = 12'hA70; 6'h19: c = 12'h0B0; 6'h1A: c = 12'h0A0; 6'h1B: c = 12'h0A4;
            6'h1C: c = 12'h088; 6'h1D: c = 12'h000; 6'h1E: c = 12'h000; 6'h1F: c = 12'h000;
            6'h20: c = 12'hFFF; 6'h21: c = 12'h3BF; 6'h22: c = 12'h68F; 6'h23: c = 12'h97F;
            6'h24: c = 12'hF7F; 6'h25: c = 12'hF59; 6'h26: c = 12'hF75; 6'h27: c = 12'hFA4;
            6'h28: c = 12'hFB0; 6'h29: c = 12'hBF1; 6'h2A: c = 12'h5D5; 6'h2B: c = 12'h5F9;
            6'h2C: c = 12'h0ED; 6'h2D: c = 12'h777; 6'h2E: c = 12'h000; 6'h2F: c = 12'h000;
            6'h30: c = 12'hFFF; 6'h31: c = 12'hAEF; 6'h32: c = 12'hBBF; 6'h33: c = 12'hDBF;
            6'h34: c = 12'hFBF; 6'h35: c = 12'hFAC; 6'h36: c = 12'hFDB; 6'h37: c = 12'hFEA;
            6'h38: c = 12'hFD7; 6'h39: c = 12'hDF7; 6'h3A: c = 12'hBFB; 6'h3B: c = 12'hBFD;
            6'h3C: c = 12'h0FF; 6'h3D: c = 12'hFDF; 6'h3E: c = 12'h000; 6'h3F: c = 12'h000;
            default: c = 12'h000;
        endcase
        return c;
`else
        // RGB332 expansion: replicate the MSBs into the vacant LSBs so that
        // full-scale inputs map to full-scale outputs.
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
`endif
    endfunction

    assign w_h_wrap = (r_h_cnt == c_h_last);
    assign w_v_wrap = (r_v_cnt == c_v_last);

    assign w_vis     = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
    assign w_img     = (r_h_cnt >= c_img_x0) && (r_h_cnt < c_img_x1) && (r_v_cnt < c_img_y1);
    assign w_hs_raw  = !((r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end));
    assign w_vs_raw  = !((r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end));
    // Each image pixel spans two screen pixels/lines, hence the halving.
    assign w_img_col = (r_h_cnt - c_img_x0) >> 1;
    assign w_img_row = r_v_cnt >> 1;

    // Stage 0: counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (pix_ce) begin
            if (w_h_wrap) begin
                r_h_cnt <= 10'd0;
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    // frame_start is produced every clk (not gated by pix_ce) so it is
    // exactly one clk wide even when pix_ce stays low afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= pix_ce && w_h_wrap && w_v_wrap;
        end
    end

    // Stage 1: read address (held outside the image) and control flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vga_row <= 10'd0;
            r_vga_col <= 10'd0;
            r_s1_img  <= 1'b0;
            r_s1_vis  <= 1'b0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
        end else if (pix_ce) begin
            if (w_img) begin
                r_vga_row <= w_img_row;
                r_vga_col <= w_img_col;
            end
            r_s1_img <= w_img;
            r_s1_vis <= w_vis;
            r_s1_hs  <= w_hs_raw;
            r_s1_vs  <= w_vs_raw;
        end
    end

    // Stage 2: the read data for the stage-1 address has settled by the next
    // pix_ce, so it is captured and converted here in one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb   <= 12'h000;
            r_de    <= 1'b0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (pix_ce) begin
            if (r_s1_img) begin
                r_rgb <= colour(vga_data);
            end else if (r_s1_vis) begin
                r_rgb <= BORDER_RGB;
            end else begin
                r_rgb <= 12'h000;
            end
            r_de    <= r_s1_vis;
            r_hsync <= r_s1_hs;
            r_vsync <= r_s1_vs;
        end
    end

    assign vga_row     = r_vga_row;
    assign vga_col     = r_vga_col;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];
    assign vblank      = (r_v_cnt >= c_v_vis);
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
